instr_batch_buffer: RTL and testbench

- Batching FIFO for 512-bit DDR4 instruction bundles, between the host DMA AXI4-Stream and the instruction decoder that turns one bundle into four DDR command slots over four clk cycles.
- It collects a complete batch, then releases it back-to-back, so DMA gaps never become command-bus bubbles that break timing-sensitive test sequences.
- A batch ends on TLAST, on an explicit fire pulse, or when the buffer is full.

---
 rtl/instr_batch_buffer_if.sv | 28 ++
 rtl/instr_batch_buffer.sv | 86 ++++++++
 tb/tb_instr_batch_buffer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_batch_buffer_if.sv
// Stream-in / stream-out bundle interface of the instruction batch buffer,
// plus the batch control and status signals.
interface instr_batch_buffer_if #(
  parameter int DATA_WIDTH = 512,
  parameter int CNT_WIDTH  = 7
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tlast;
  logic                  s_axis_tready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  fire;
  logic [CNT_WIDTH-1:0]  count;
  logic                  draining;
  logic                  batch_done;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, fire,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, count, draining, batch_done
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, fire,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, count, draining, batch_done
  );
endinterface

// File: rtl/instr_batch_buffer.sv
// Batching FIFO: fills until tlast, fire or full, then drains the whole batch
// back-to-back so DMA gaps never reach the DDR command bus.
//   state | meaning
//   FILL  | accepting bundles from DMA, output idle
//   DRAIN | releasing stored bundles to the decoder, input blocked
module instr_batch_buffer #(
  parameter int DATA_WIDTH     = 512,
  parameter int DEPTH          = 64,
  parameter bit AUTO_FIRE_FULL = 1'b1,
  parameter int CNT_WIDTH      = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_batch_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic                  r_batch_done;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_s_ready;
  logic w_m_valid;
  logic w_wr;
  logic w_rd;
  logic w_trigger;

  // Handshake qualifiers depend only on registered state/count (and reset).
  assign w_s_ready = !rst && (r_state == FILL) && (r_count < FULL);
  assign w_m_valid = (r_state == DRAIN) && (r_count != '0);
  assign w_wr      = w_s_ready && bus.s_axis_tvalid;
  assign w_rd      = w_m_valid && bus.m_axis_tready;

  assign w_trigger = (w_wr && bus.s_axis_tlast) ||
                     (bus.fire && ((r_count != '0) || w_wr)) ||
                     (AUTO_FIRE_FULL && w_wr && (r_count == FULL - 1'b1));

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FILL;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_batch_done <= 1'b0;
    end else begin
      r_batch_done <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count  <= r_count + 1'b1;
          end
          if (w_trigger) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count  <= r_count - 1'b1;
            if (r_count == CNT_WIDTH'(1)) begin
              r_batch_done <= 1'b1;
              r_state      <= FILL;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.s_axis_tready = w_s_ready;
  assign bus.m_axis_tvalid = w_m_valid;
  assign bus.m_axis_tdata  = r_mem[r_rd_ptr];
  assign bus.count         = r_count;
  assign bus.draining      = (r_state == DRAIN);
  assign bus.batch_done    = r_batch_done;
endmodule

// File: tb/tb_instr_batch_buffer.sv
// Randomized scoreboard bench for instr_batch_buffer, plus a directed check
// of the hold-at-full behaviour when automatic firing is disabled.
module tb_instr_batch_buffer;
  localparam int DW    = 512;
  localparam int DEPTH = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_batch_buffer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  instr_batch_buffer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus0 ();

  instr_batch_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AUTO_FIRE_FULL(1'b1), .CNT_WIDTH(CW))
    u_dut (.clk(clk), .rst(rst), .bus(bus));
  instr_batch_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AUTO_FIRE_FULL(1'b0), .CNT_WIDTH(CW))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered queue of accepted bundles, occupancy and phase.
  logic [DW-1:0] exp_q[$];
  int            m_cnt = 0;
  bit            m_drain = 0;
  bit            m_bd = 0;
  logic [DW-1:0] held;
  bit            held_v = 0;
  bit            wr, rd, trig;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_s_tready", bus.s_axis_tready, 0);
      exp_q.delete();
      m_cnt = 0; m_drain = 0; m_bd = 0; held_v = 0;
    end else begin
      chk("count", bus.count, m_cnt);
      chk("draining", bus.draining, m_drain);
      chk("batch_done", bus.batch_done, m_bd);
      chk("s_tready", bus.s_axis_tready, !m_drain && (m_cnt < DEPTH));
      chk("m_tvalid", bus.m_axis_tvalid, m_drain && (m_cnt > 0));
      wr = bus.s_axis_tvalid && bus.s_axis_tready;
      rd = bus.m_axis_tvalid && bus.m_axis_tready;
      if (held_v && bus.m_axis_tvalid) chk("hold_tdata", bus.m_axis_tdata, held);
      held_v = bus.m_axis_tvalid && !bus.m_axis_tready;
      held   = bus.m_axis_tdata;
      if (wr) exp_q.push_back(bus.s_axis_tdata);
      if (rd) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out act=%0h exp=none", bus.m_axis_tdata);
        end else begin
          chk("out_data", bus.m_axis_tdata, exp_q.pop_front());
        end
      end
      m_bd = 0;
      if (!m_drain) begin
        trig = (wr && bus.s_axis_tlast) || (bus.fire && (m_cnt > 0 || wr)) ||
               (m_cnt + int'(wr) == DEPTH);
        m_cnt += int'(wr);
        m_drain = trig;
      end else if (rd) begin
        m_cnt--;
        if (m_cnt == 0) begin m_drain = 0; m_bd = 1; end
      end
    end
  end

  // Decoder-side ready: 0 = always, 1 = one cycle in four, 2 = random, 3 = never.
  int rdy_mode = 0;
  int cyc = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0: bus.m_axis_tready = 1'b1;
      1: bus.m_axis_tready = (cyc % 4 == 0);
      2: bus.m_axis_tready = 1'($urandom_range(0, 1));
      default: bus.m_axis_tready = 1'b0;
    endcase
  end

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [DW-1:0] d, input bit last);
    int n = 0;
    bus.s_axis_tdata = d; bus.s_axis_tlast = last; bus.s_axis_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.s_axis_tready) break;
      n++;
      if (n > 3000) begin
        total++; bad++;
        $display("FAIL send_timeout act=tready_low exp=tready_high");
        break;
      end
    end
    @(posedge clk); #1;
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
  endtask

  task automatic pulse_fire();
    bus.fire = 1'b1;
    @(posedge clk); #1;
    bus.fire = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!bus.draining && bus.count == 0) break;
      n++;
      if (n > 5000) begin
        total++; bad++;
        $display("FAIL idle_timeout act=count%0d exp=count0", bus.count);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n, got, len;
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0;
    bus.fire = 0; bus.m_axis_tready = 0;
    bus0.s_axis_tdata = '0; bus0.s_axis_tvalid = 0; bus0.s_axis_tlast = 0;
    bus0.fire = 0; bus0.m_axis_tready = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_count", bus.count, 0);
    chk("reset_s_tready", bus.s_axis_tready, 1);
    @(posedge clk); #1;

    // three bundles released by fire
    rdy_mode = 0;
    for (int i = 1; i <= 3; i++) send(DW'(i), 1'b0);
    pulse_fire();
    wait_idle();

    // five bundles closed by tlast
    for (int i = 1; i <= 5; i++) send(DW'(16 + i), i == 5);
    wait_idle();

    // continuous 64-beat stream triggers the full auto-fire
    for (int i = 0; i < DEPTH; i++) send(rnd_data(), 1'b0);
    wait_idle();

    // sparse decoder ready: 8 bundles drain in 29..32 cycles
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send(rnd_data(), i == 7);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.draining) n++;
      if (bus.batch_done) break;
    end
    chk("sparse_drain_cycles_ok", (n >= 29 && n <= 32), 1);
    @(posedge clk); #1;
    wait_idle();

    // fire on an empty buffer is ignored
    rdy_mode = 0;
    pulse_fire();
    idle(3);
    @(negedge clk);
    chk("empty_fire_draining", bus.draining, 0);
    @(posedge clk); #1;

    // reset in the middle of a stalled drain
    rdy_mode = 3;
    for (int i = 0; i < 10; i++) send(rnd_data(), i == 9);
    idle(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_count", bus.count, 0);
    chk("midrst_m_tvalid", bus.m_axis_tvalid, 0);
    chk("midrst_draining", bus.draining, 0);
    @(posedge clk); #1;
    rdy_mode = 0;
    send(DW'(32'hA1), 1'b0);
    send(DW'(32'hA2), 1'b1);
    wait_idle();

    // randomized batches, gaps, random ready and occasional stray fire
    rdy_mode = 2;
    for (int b = 0; b < 25; b++) begin
      len = $urandom_range(1, 75);
      for (int i = 0; i < len; i++) begin
        send(rnd_data(), ($urandom_range(0, 1) == 0) && (i == len - 1));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        if ($urandom_range(0, 30) == 0) pulse_fire();
      end
      pulse_fire();
      wait_idle();
    end

    // no auto-fire: buffer holds at full until fire
    rdy_mode = 0;
    bus0.s_axis_tvalid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus0.s_axis_tdata = DW'(i + 1);
      @(negedge clk);
      chk("nofire_fill_tready", bus0.s_axis_tready, 1);
      @(posedge clk); #1;
    end
    bus0.s_axis_tvalid = 1'b0;
    idle(4);
    @(negedge clk);
    chk("nofire_full_count", bus0.count, DEPTH);
    chk("nofire_full_tready", bus0.s_axis_tready, 0);
    chk("nofire_full_draining", bus0.draining, 0);
    @(posedge clk); #1;
    bus0.fire = 1'b1; bus0.m_axis_tready = 1'b1;
    @(posedge clk); #1;
    bus0.fire = 1'b0;
    got = 0;
    for (int k = 0; k < 300 && got < DEPTH; k++) begin
      @(negedge clk);
      if (bus0.m_axis_tvalid && bus0.m_axis_tready) begin
        chk("nofire_out_data", bus0.m_axis_tdata, DW'(got + 1));
        got++;
      end
    end
    chk("nofire_out_total", got, DEPTH);
    @(negedge clk);
    chk("nofire_batch_done", bus0.batch_done, 1);
    @(negedge clk);
    chk("nofire_ready_again", bus0.s_axis_tready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
